// File: rtl/multi_debouncer_pkg.sv
// Shared FSM encoding, default constants and counter sizing for multi_debouncer.
// The optional long-press detector is enabled with DEBOUNCE_LONGPRESS_EN.
`timescale 1ns/100ps
package multi_debouncer_pkg;

  typedef enum logic {
    ST_STABLE  = 1'b0,
    ST_PENDING = 1'b1
  } state_t;

  localparam int DEF_STABLE_CYCLES = 8;
  localparam int DEF_SYNC_STAGES   = 2;
  localparam int DEF_LONG_CYCLES   = 64;

  // Stability counter only needs to reach STABLE_CYCLES-1, never less than one bit.
  function automatic int cnt_width(input int stable_cycles);
    return ($clog2(stable_cycles) > 1) ? $clog2(stable_cycles) : 1;
  endfunction

endpackage

// File: rtl/multi_debouncer_debounce_channel.sv
// One debounced input: synchroniser, two-state FSM with stability counter, edge pulses.
// Long-press pulse and hold counter exist only when DEBOUNCE_LONGPRESS_EN is defined.
`timescale 1ns/100ps
module debounce_channel
  import multi_debouncer_pkg::*;
#(
  parameter int STABLE_CYCLES = DEF_STABLE_CYCLES,
  parameter int SYNC_STAGES   = DEF_SYNC_STAGES
`ifdef DEBOUNCE_LONGPRESS_EN
  , parameter int LONG_CYCLES = DEF_LONG_CYCLES
`endif
) (
  input  logic clk,
  input  logic rst,
  input  logic btn,
  output logic out,
  output logic rise,
  output logic fall
`ifdef DEBOUNCE_LONGPRESS_EN
  , output logic long_press
`endif
);

  localparam int CNT_W = cnt_width(STABLE_CYCLES);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(STABLE_CYCLES - 1);

  logic [SYNC_STAGES-1:0] sync_q;
  logic                   sync;
  state_t                 state, state_nxt;
  logic [CNT_W-1:0]       cnt, cnt_nxt;
  logic                   out_nxt, rise_nxt, fall_nxt;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) sync_q <= '0;
    else     sync_q <= {sync_q[SYNC_STAGES-2:0], btn};
  end

  assign sync = sync_q[SYNC_STAGES-1];

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state <= ST_STABLE;
      cnt   <= '0;
      out   <= 1'b0;
      rise  <= 1'b0;
      fall  <= 1'b0;
    end else begin
      state <= state_nxt;
      cnt   <= cnt_nxt;
      out   <= out_nxt;
      rise  <= rise_nxt;
      fall  <= fall_nxt;
    end
  end

  // A bounce back to the current level abandons the pending count.
  always_comb begin
    state_nxt = state;
    cnt_nxt   = cnt;
    out_nxt   = out;
    unique case (state)
      ST_STABLE: begin
        cnt_nxt = '0;
        if (sync != out) begin
          state_nxt = ST_PENDING;
          cnt_nxt   = CNT_W'(1);
        end
      end
      ST_PENDING: begin
        if (sync == out) begin
          state_nxt = ST_STABLE;
          cnt_nxt   = '0;
        end else if (cnt == CNT_LAST) begin
          state_nxt = ST_STABLE;
          cnt_nxt   = '0;
          out_nxt   = ~out;
        end else begin
          cnt_nxt = cnt + CNT_W'(1);
        end
      end
    endcase
  end

  always_comb begin
    rise_nxt = out_nxt & ~out;
    fall_nxt = ~out_nxt & out;
  end

`ifdef DEBOUNCE_LONGPRESS_EN
  localparam int HOLD_W = $clog2(LONG_CYCLES + 1);
  localparam logic [HOLD_W-1:0] HOLD_MAX = HOLD_W'(LONG_CYCLES);

  logic [HOLD_W-1:0] hold;

  // Saturating at HOLD_MAX gives exactly one pulse per press.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      hold       <= '0;
      long_press <= 1'b0;
    end else if (!out) begin
      hold       <= '0;
      long_press <= 1'b0;
    end else if (hold != HOLD_MAX) begin
      hold       <= hold + HOLD_W'(1);
      long_press <= (hold == HOLD_MAX - HOLD_W'(1));
    end else begin
      long_press <= 1'b0;
    end
  end
`endif

endmodule

// File: rtl/multi_debouncer.sv
// N_CH independent debounce channels; long_press port exists only with DEBOUNCE_LONGPRESS_EN.
`timescale 1ns/100ps
module multi_debouncer
  import multi_debouncer_pkg::*;
#(
  parameter int N_CH          = 4,
  parameter int STABLE_CYCLES = DEF_STABLE_CYCLES,
  parameter int SYNC_STAGES   = DEF_SYNC_STAGES
`ifdef DEBOUNCE_LONGPRESS_EN
  , parameter int LONG_CYCLES = DEF_LONG_CYCLES
`endif
) (
  input  logic            clk,
  input  logic            rst,
  input  logic [N_CH-1:0] btn,
  output logic [N_CH-1:0] out,
  output logic [N_CH-1:0] rise,
  output logic [N_CH-1:0] fall
`ifdef DEBOUNCE_LONGPRESS_EN
  , output logic [N_CH-1:0] long_press
`endif
);

  for (genvar i = 0; i < N_CH; i++) begin : g_ch
    debounce_channel #(
      .STABLE_CYCLES(STABLE_CYCLES),
      .SYNC_STAGES  (SYNC_STAGES)
`ifdef DEBOUNCE_LONGPRESS_EN
      , .LONG_CYCLES(LONG_CYCLES)
`endif
    ) u_ch (
      .clk (clk),
      .rst (rst),
      .btn (btn[i]),
      .out (out[i]),
      .rise(rise[i]),
      .fall(fall[i])
`ifdef DEBOUNCE_LONGPRESS_EN
      , .long_press(long_press[i])
`endif
    );
  end

endmodule

// File: tb/tb_multi_debouncer.sv
// Scoreboard bench for multi_debouncer: directed scenarios then random bouncing,
// expected levels/pulses derived from a sliding window over sampled button history.
`timescale 1ns/100ps
module tb_multi_debouncer;

  localparam int N_CH          = 4;
  localparam int STABLE_CYCLES = 4;
  localparam int SYNC_STAGES   = 2;
  localparam int LONG_CYCLES   = 10;
  localparam int DEPTH         = SYNC_STAGES + STABLE_CYCLES;
  localparam int N_DIR         = 15;

  typedef struct packed {
    logic [N_CH-1:0] out;
    logic [N_CH-1:0] rise;
    logic [N_CH-1:0] fall;
    logic [N_CH-1:0] lp;
  } exp_t;

  logic            clk = 1'b0;
  logic            rst = 1'b1;
  logic [N_CH-1:0] btn = '0;
  logic [N_CH-1:0] out, rise, fall;
`ifdef DEBOUNCE_LONGPRESS_EN
  logic [N_CH-1:0] long_press;
`endif

  int n_err = 0;
  int n_chk = 0;

  exp_t            exp_q[$];
  logic [N_CH-1:0] hist[$];
  logic [N_CH-1:0] m_out;
  int              hold[N_CH];

  // 0 in dir_n means: pulse reset once while driving that pattern
  logic [N_CH-1:0] dir_b [N_DIR] = '{4'b0000, 4'b0001, 4'b0011, 4'b0001, 4'b0101,
                                     4'b0001, 4'b0101, 4'b1100, 4'b1110, 4'b1110,
                                     4'b1110, 4'b1111, 4'b1110, 4'b1111, 4'b0000};
  int              dir_n [N_DIR] = '{3, 10, 2, 8, 1, 1, 10, 10, 2, 0, 10, 30, 5, 20, 10};

  multi_debouncer #(
    .N_CH         (N_CH),
    .STABLE_CYCLES(STABLE_CYCLES),
    .SYNC_STAGES  (SYNC_STAGES)
`ifdef DEBOUNCE_LONGPRESS_EN
    , .LONG_CYCLES(LONG_CYCLES)
`endif
  ) dut (
    .clk (clk),
    .rst (rst),
    .btn (btn),
    .out (out),
    .rise(rise),
    .fall(fall)
`ifdef DEBOUNCE_LONGPRESS_EN
    , .long_press(long_press)
`endif
  );

  always #2 clk = ~clk;

  function automatic void model_reset();
    hist.delete();
    for (int k = 0; k < DEPTH; k++) hist.push_back('0);
    m_out = '0;
    for (int c = 0; c < N_CH; c++) hold[c] = 0;
  endfunction

  // out flips when every level the FSM saw over the last STABLE_CYCLES edges
  // (samples taken SYNC_STAGES edges earlier) differs from the current out.
  function automatic exp_t model_step(input logic [N_CH-1:0] b);
    exp_t            e;
    logic [N_CH-1:0] w;
    bit              flip;
    e = '0;
    hist.push_back(b);
    void'(hist.pop_front());
    for (int c = 0; c < N_CH; c++) begin
      flip = 1'b1;
      for (int k = 0; k < STABLE_CYCLES; k++) begin
        w = hist[k];
        if (w[c] == m_out[c]) flip = 1'b0;
      end
      if (m_out[c]) begin
        if (hold[c] < LONG_CYCLES) begin
          hold[c]++;
          if (hold[c] == LONG_CYCLES) e.lp[c] = 1'b1;
        end
      end else begin
        hold[c] = 0;
      end
      if (flip) begin
        e.rise[c] = ~m_out[c];
        e.fall[c] = m_out[c];
        m_out[c]  = ~m_out[c];
      end
    end
    e.out = m_out;
    return e;
  endfunction

  task automatic applyStimulus(input logic [N_CH-1:0] b, input bit do_rst);
    @(negedge clk);
    btn = b;
    if (do_rst) begin
      model_reset();
      exp_q.push_back('0);
      #0.5 rst = 1'b1;
      #3   rst = 1'b0;
    end else begin
      rst = 1'b0;
      exp_q.push_back(model_step(b));
    end
  endtask

  task automatic checkOutput(input string name, input logic [N_CH-1:0] act,
                             input logic [N_CH-1:0] req);
    n_chk++;
    if (act !== req) begin
      n_err++;
      $display("[TB] FAIL %s: got %b expected %b at %0t", name, act, req, $time);
    end
  endtask

  initial begin : monitor
    forever begin : sample
      exp_t e;
      @(posedge clk);
      #1;
      if (exp_q.size() > 0) begin
        e = exp_q.pop_front();
        checkOutput("out", out, e.out);
        checkOutput("rise", rise, e.rise);
        checkOutput("fall", fall, e.fall);
        checkOutput("rise_and_fall", rise & fall, '0);
`ifdef DEBOUNCE_LONGPRESS_EN
        checkOutput("long_press", long_press, e.lp);
`endif
      end
    end
  end

  initial begin : stimulus
    int              left[N_CH];
    logic [N_CH-1:0] lvl;
    model_reset();
    repeat (2) begin
      @(negedge clk);
      exp_q.push_back('0);
    end
    for (int i = 0; i < N_DIR; i++) begin
      if (dir_n[i] == 0) applyStimulus(dir_b[i], 1'b1);
      else repeat (dir_n[i]) applyStimulus(dir_b[i], 1'b0);
    end
    lvl = '0;
    for (int c = 0; c < N_CH; c++) left[c] = 0;
    for (int cyc = 0; cyc < 400; cyc++) begin
      for (int c = 0; c < N_CH; c++) begin
        if (left[c] == 0) begin
          lvl[c]  = 1'($urandom_range(0, 1));
          left[c] = $urandom_range(1, 9);
        end
        left[c]--;
      end
      applyStimulus(lvl, (cyc % 137) == 136);
    end
    repeat (3) @(negedge clk);
    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end

endmodule
